// File: rtl/b2a_pkg.sv
// Shared definitions for the Boolean-to-arithmetic share-folding datapath.
package b2a_pkg;

  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 8;

  // Total width of a masked bus: one K-bit lane per share.
  function automatic int maskwidth(input int k_width, input int n_shares);
    return k_width * n_shares;
  endfunction

  // The active-share counter must be able to hold N_SHARES itself.
  function automatic int cnt_width(input int n_shares);
    return $clog2(n_shares) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_SHARES_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sec_fx_state_t;

endpackage

// File: rtl/sec_ref_fold.sv
// One combinational refresh-and-fold round over the active shares s[0..cnt-1].
// Every active share above s[0] is re-masked with its own random lane before
// the top active share is folded into s[0], so no XOR of two unrefreshed
// shares is ever formed.
module sec_ref_fold
  import b2a_pkg::*;
#(
  parameter int  K_WIDTH  = K_WIDTH_DEF,
  parameter int  N_SHARES = N_SHARES_DEF,
  localparam int CW       = cnt_width(N_SHARES)
) (
  input  logic [K_WIDTH*N_SHARES-1:0]     s_in,
  input  logic [(N_SHARES-1)*K_WIDTH-1:0] rnd,
  input  logic [CW-1:0]                   cnt,
  output logic [K_WIDTH*N_SHARES-1:0]     s_out
);

  logic [K_WIDTH-1:0] t [N_SHARES];

  // Refresh active lanes pairwise with s[0], then fold the refreshed top share.
  always_comb begin
    for (int i = 0; i < N_SHARES; i++) begin
      t[i] = s_in[i*K_WIDTH +: K_WIDTH];
    end
    for (int j = 1; j < N_SHARES; j++) begin
      if (j < int'(cnt)) begin
        t[0] = t[0] ^ rnd[(j-1)*K_WIDTH +: K_WIDTH];
        t[j] = t[j] ^ rnd[(j-1)*K_WIDTH +: K_WIDTH];
      end
    end
    for (int j = 1; j < N_SHARES; j++) begin
      if (j == int'(cnt) - 1) begin
        t[0] = t[0] ^ t[j];
      end
    end
    s_out = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      s_out[i*K_WIDTH +: K_WIDTH] = t[i];
    end
  end

endmodule

// File: rtl/sec_full_xor.sv
// Unmasks N Boolean shares into a single K-bit value by repeated
// refresh-and-fold rounds, one round per enabled clock edge.
module sec_full_xor
  import b2a_pkg::*;
#(
  parameter int  K_WIDTH   = K_WIDTH_DEF,
  parameter int  N_SHARES  = N_SHARES_DEF,
  localparam int MASKWIDTH = maskwidth(K_WIDTH, N_SHARES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           dvld,
  input  logic [(N_SHARES-1)*K_WIDTH-1:0] rnd,
  input  logic [MASKWIDTH-1:0]           z,
  output logic [K_WIDTH-1:0]             res,
  output logic                           ovld,
  output logic                           busy
);

  localparam int            CW       = cnt_width(N_SHARES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_SHARES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  sec_fx_state_t        state;
  sec_fx_state_t        state_nxt;
  logic [CW-1:0]        cnt;
  logic [MASKWIDTH-1:0] s;
  logic [MASKWIDTH-1:0] s_fold;

  sec_ref_fold #(
    .K_WIDTH  (K_WIDTH),
    .N_SHARES (N_SHARES)
  ) u_ref_fold (
    .s_in  (s),
    .rnd   (rnd),
    .cnt   (cnt),
    .s_out (s_fold)
  );

  // State register; holds whenever the global enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Next state: the round that brings cnt down to one ends the conversion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (dvld) state_nxt = RUN;
      RUN:     if (cnt <= CNT_TWO) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy decodes straight from the state register, so no input reaches it.
  always_comb begin
    busy = (state != IDLE);
  end

  // Share array and active count: load in IDLE, one round per enabled RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      s   <= '0;
    end else if (ena) begin
      if (state == IDLE && dvld) begin
        s   <= z;
        cnt <= CNT_LOAD;
      end else if (state == RUN) begin
        s   <= s_fold;
        cnt <= (cnt > CNT_ONE) ? cnt - CNT_ONE : CNT_ONE;
      end
    end
  end

  // Result register captures the final s[0]; ovld pulses for the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res  <= '0;
      ovld <= 1'b0;
    end else if (ena) begin
      if (state == RUN && state_nxt == DONE) begin
        res  <= s_fold[K_WIDTH-1:0];
        ovld <= 1'b1;
      end else begin
        ovld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sec_full_xor.sv
// Directed bench for sec_full_xor with K_WIDTH=32, N_SHARES=8.
module tb_sec_full_xor;

  localparam int K  = 32;
  localparam int N  = 8;
  localparam int MW = K * N;
  localparam int RW = (N - 1) * K;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          dvld;
  logic [RW-1:0] rnd;
  logic [MW-1:0] z;
  logic [K-1:0]  res;
  logic          ovld;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit rnd_zero = 1'b0;

  always #5 clk = ~clk;

  sec_full_xor #(
    .K_WIDTH  (K),
    .N_SHARES (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .dvld  (dvld),
    .rnd   (rnd),
    .z     (z),
    .res   (res),
    .ovld  (ovld),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [K-1:0] got, input logic [K-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [K-1:0] xor_all(input logic [MW-1:0] v);
    logic [K-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc ^ v[i*K +: K];
    return acc;
  endfunction

  function automatic logic [MW-1:0] rand_z();
    logic [MW-1:0] v;
    for (int i = 0; i < N; i++) v[i*K +: K] = $urandom();
    return v;
  endfunction

  task automatic new_rnd();
    for (int i = 0; i < N - 1; i++) rnd[i*K +: K] = rnd_zero ? '0 : $urandom();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    new_rnd();
  endtask

  // Load zv, then count edges until ovld shows; optional 3-cycle stall after
  // stall_after rounds.
  task automatic load_and_wait(input logic [MW-1:0] zv, input int stall_after, output int lat);
    z    = zv;
    dvld = 1'b1;
    step();
    dvld = 1'b0;
    lat  = 0;
    while (ovld !== 1'b1 && lat < 40) begin
      if (lat == stall_after) begin
        ena = 1'b0;
        repeat (3) step();
        ena = 1'b1;
        lat += 3;
      end
      step();
      lat++;
    end
  endtask

  initial begin
    logic [MW-1:0] zv;
    logic [MW-1:0] loadz;
    logic [K-1:0]  exp;
    int            lat;
    bit            seen;

    rst_n = 1'b0;
    ena   = 1'b1;
    dvld  = 1'b0;
    z     = '0;
    new_rnd();
    #3;
    chk("rst_ovld", ovld, 0);
    chk("rst_res", res, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Zero-mask conversion with zero randomness, checked cycle by cycle.
    rnd_zero = 1'b1;
    new_rnd();
    zv = '0;
    zv[K-1:0] = 32'h12345678;
    z    = zv;
    dvld = 1'b1;
    step();
    dvld = 1'b0;
    chk("zm_busy_t0", busy, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("zm_ovld_t%0d", i), ovld, 0);
      chk($sformatf("zm_busy_t%0d", i), busy, 1);
    end
    step();
    chk("zm_ovld_t7", ovld, 1);
    chk("zm_res_t7", res, 32'h12345678);
    chk("zm_busy_t7", busy, 1);
    step();
    chk("zm_ovld_t8", ovld, 0);
    chk("zm_busy_t8", busy, 0);
    chk("zm_res_hold", res, 32'h12345678);
    rnd_zero = 1'b0;
    new_rnd();

    // Shares chosen to unmask to 0xDEADBEEF.
    zv = rand_z();
    zv[(N-1)*K +: K] = '0;
    zv[(N-1)*K +: K] = xor_all(zv) ^ 32'hDEADBEEF;
    load_and_wait(zv, -1, lat);
    chk("db_lat", lat, 7);
    chk("db_res", res, 32'hDEADBEEF);
    step();
    chk("db_ovld_drop", ovld, 0);

    // Random shares with fresh randomness every cycle.
    for (int n = 0; n < 300; n++) begin
      zv  = rand_z();
      exp = xor_all(zv);
      load_and_wait(zv, -1, lat);
      chk($sformatf("rnd%0d_lat", n), lat, 7);
      chk($sformatf("rnd%0d_res", n), res, exp);
      step();
    end

    // Stall three cycles during round 4, then freeze while ovld is high.
    zv  = rand_z();
    exp = xor_all(zv);
    load_and_wait(zv, 3, lat);
    chk("stall_lat", lat, 10);
    chk("stall_res", res, exp);
    ena = 1'b0;
    step();
    step();
    chk("frz_ovld", ovld, 1);
    chk("frz_res", res, exp);
    chk("frz_busy", busy, 1);
    ena = 1'b1;
    step();
    chk("frz_ovld_drop", ovld, 0);
    chk("frz_busy_drop", busy, 0);
    chk("frz_res_hold", res, exp);

    // dvld held high with z changing every cycle: loads every 9 cycles.
    loadz = '0;
    dvld  = 1'b1;
    for (int i = 0; i < 36; i++) begin
      z = rand_z();
      if (i % 9 == 0) loadz = z;
      step();
      chk($sformatf("bz_ovld_c%0d", i), ovld, (i % 9 == 7) ? 1 : 0);
      if (i % 9 == 7) chk($sformatf("bz_res_c%0d", i), res, xor_all(loadz));
    end
    dvld = 1'b0;

    // Reset asserted mid-conversion in round 4.
    zv   = rand_z();
    z    = zv;
    dvld = 1'b1;
    step();
    dvld = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ovld", ovld, 0);
    chk("mrst_res", res, 0);
    chk("mrst_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ovld !== 1'b0) seen = 1'b1;
    end
    chk("mrst_no_ovld", seen, 0);
    zv  = rand_z();
    exp = xor_all(zv);
    load_and_wait(zv, -1, lat);
    chk("post_rst_lat", lat, 7);
    chk("post_rst_res", res, exp);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
